// File: rtl/wb_stage.sv
// Writeback stage: load extraction, result select, main/ext arbitration
// with a starvation guard, and registered register-file write port.
//
// Ports:
//   clk, reset (async, active-low)
//   in_*   : main-pipe beat from the memory stage (valid/ready, flush)
//   ext_*  : long-latency unit result (valid/ready)
//   rg_wrt_en/addr/data : registered register-file write port
module wb_stage #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_flush,
  input  logic        in_reg_write,
  input  logic [4:0]  in_rd,
  input  logic [1:0]  in_wb_sel,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_mem_rdata,
  input  logic [31:0] in_pc_plus4,
  input  logic        ext_valid,
  output logic        ext_ready,
  input  logic [4:0]  ext_rd,
  input  logic [31:0] ext_data,
  output logic        rg_wrt_en,
  output logic [4:0]  rg_wrt_addr,
  output logic [31:0] rg_wrt_data
);

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  logic [3:0]  wait_cnt;
  logic        main_live;
  logic        starve;
  logic        ext_acc;
  logic        main_acc;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_val;
  logic [31:0] main_data;

  // A flushed beat is consumed silently and never competes for the port.
  assign main_live = in_valid & ~in_flush;
  assign starve    = (wait_cnt == LIM);
  assign ext_ready = starve | ~main_live;
  assign in_ready  = ~(ext_valid & starve);
  assign ext_acc   = ext_valid & ext_ready;
  assign main_acc  = main_live & in_ready & ~ext_acc;

  always_comb begin
    ld_b = in_mem_rdata[7:0];
    unique case (in_addr_lo)
      2'd0: ld_b = in_mem_rdata[7:0];
      2'd1: ld_b = in_mem_rdata[15:8];
      2'd2: ld_b = in_mem_rdata[23:16];
      2'd3: ld_b = in_mem_rdata[31:24];
    endcase
  end

  assign ld_h = in_addr_lo[1] ? in_mem_rdata[31:16]
                              : in_mem_rdata[15:0];

  always_comb begin
    ld_val = in_mem_rdata;
    case (in_funct3)
      3'b000:  ld_val = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_val = {{16{ld_h[15]}}, ld_h};
      3'b100:  ld_val = {24'd0, ld_b};
      3'b101:  ld_val = {16'd0, ld_h};
      default: ld_val = in_mem_rdata;
    endcase
  end

  always_comb begin
    main_data = in_alu_result;
    unique case (1'b1)
      (in_wb_sel == 2'b01): main_data = ld_val;
      (in_wb_sel == 2'b10): main_data = in_pc_plus4;
      default:              main_data = in_alu_result;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt    <= '0;
      rg_wrt_en   <= 1'b0;
      rg_wrt_addr <= '0;
      rg_wrt_data <= '0;
    end else begin
      if (!ext_valid || ext_acc)
        wait_cnt <= '0;
      else if (!starve)
        wait_cnt <= wait_cnt + 4'd1;

      rg_wrt_en <= 1'b0;
      if (ext_acc && ext_rd != 5'd0) begin
        rg_wrt_en   <= 1'b1;
        rg_wrt_addr <= ext_rd;
        rg_wrt_data <= ext_data;
      end else if (main_acc && in_reg_write
                   && in_rd != 5'd0) begin
        rg_wrt_en   <= 1'b1;
        rg_wrt_addr <= in_rd;
        rg_wrt_data <= main_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: vector table, hand sequences and
// random traffic against a behavioural model.
module tb_wb_stage;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_flush;
  logic        in_reg_write;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_result;
  logic [31:0] in_mem_rdata;
  logic [31:0] in_pc_plus4;
  logic        ext_valid;
  logic        ext_ready;
  logic [4:0]  ext_rd;
  logic [31:0] ext_data;
  logic        rg_wrt_en;
  logic [4:0]  rg_wrt_addr;
  logic [31:0] rg_wrt_data;

  wb_stage #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_flush(in_flush), .in_reg_write(in_reg_write),
    .in_rd(in_rd), .in_wb_sel(in_wb_sel),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .in_alu_result(in_alu_result),
    .in_mem_rdata(in_mem_rdata),
    .in_pc_plus4(in_pc_plus4),
    .ext_valid(ext_valid), .ext_ready(ext_ready),
    .ext_rd(ext_rd), .ext_data(ext_data),
    .rg_wrt_en(rg_wrt_en), .rg_wrt_addr(rg_wrt_addr),
    .rg_wrt_data(rg_wrt_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          m_wait;
  logic        m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_ext_acc;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_data();
    logic [31:0] b;
    logic [31:0] h;
    b = (in_mem_rdata >> (8 * in_addr_lo)) & 32'hFF;
    h = (in_mem_rdata >> (16 * (in_addr_lo / 2))) & 32'hFFFF;
    if (in_wb_sel == 2'd2) return in_pc_plus4;
    if (in_wb_sel != 2'd1) return in_alu_result;
    case (in_funct3)
      3'd0: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd1: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd4: return b;
      3'd5: return h;
      default: return in_mem_rdata;
    endcase
  endfunction

  // Called at a negedge with inputs already applied.
  task automatic step();
    bit st, er, ir, ea, ma;
    #1;
    st = (m_wait >= LIMIT);
    er = st || !(in_valid && !in_flush);
    ir = !(ext_valid && st);
    chk("ext_ready", 32'(ext_ready), 32'(er));
    chk("in_ready", 32'(in_ready), 32'(ir));
    ea = ext_valid && er;
    ma = in_valid && !in_flush && ir && !ea;
    m_ext_acc = ea;
    @(posedge clk);
    m_en = 1'b0;
    if (ea && ext_rd != 0) begin
      m_en = 1'b1; m_addr = ext_rd; m_data = ext_data;
    end else if (ma && in_reg_write && in_rd != 0) begin
      m_en = 1'b1; m_addr = in_rd; m_data = ref_data();
    end
    if (ext_valid && !ea)
      m_wait = (m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1;
    else
      m_wait = 0;
    #1;
    chk("wr_en", 32'(rg_wrt_en), 32'(m_en));
    chk("wr_addr", 32'(rg_wrt_addr), 32'(m_addr));
    chk("wr_data", rg_wrt_data, m_data);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_flush = 0; in_reg_write = 0;
    in_rd = 0; in_wb_sel = 0; in_funct3 = 0;
    in_addr_lo = 0; in_alu_result = 0;
    in_mem_rdata = 0; in_pc_plus4 = 0;
    ext_valid = 0; ext_rd = 0; ext_data = 0;
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic        exp_en;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vt[14];

  initial begin
    vt[0]  = '{2'd1, 3'd0, 2'd0, 5'd1, 32'h0,
               32'h80F1_7F82, 32'h0, 1'b1, 32'hFFFF_FF82};
    vt[1]  = '{2'd1, 3'd0, 2'd1, 5'd2, 32'h0,
               32'h80F1_7F82, 32'h0, 1'b1, 32'h0000_007F};
    vt[2]  = '{2'd1, 3'd0, 2'd2, 5'd3, 32'h0,
               32'h80F1_7F82, 32'h0, 1'b1, 32'hFFFF_FFF1};
    vt[3]  = '{2'd1, 3'd0, 2'd3, 5'd4, 32'h0,
               32'h80F1_7F82, 32'h0, 1'b1, 32'hFFFF_FF80};
    vt[4]  = '{2'd1, 3'd5, 2'd2, 5'd6, 32'h0,
               32'h80F1_7F82, 32'h0, 1'b1, 32'h0000_80F1};
    vt[5]  = '{2'd1, 3'd1, 2'd0, 5'd7, 32'h0,
               32'h80F1_7F82, 32'h0, 1'b1, 32'h0000_7F82};
    vt[6]  = '{2'd1, 3'd1, 2'd3, 5'd8, 32'h0,
               32'h80F1_7F82, 32'h0, 1'b1, 32'hFFFF_80F1};
    vt[7]  = '{2'd1, 3'd4, 2'd3, 5'd9, 32'h0,
               32'h80F1_7F82, 32'h0, 1'b1, 32'h0000_0080};
    vt[8]  = '{2'd1, 3'd2, 2'd1, 5'd10, 32'h0,
               32'h80F1_7F82, 32'h0, 1'b1, 32'h80F1_7F82};
    vt[9]  = '{2'd1, 3'd3, 2'd0, 5'd11, 32'h0,
               32'h80F1_7F82, 32'h0, 1'b1, 32'h80F1_7F82};
    vt[10] = '{2'd2, 3'd0, 2'd0, 5'd5, 32'h55,
               32'h0, 32'h104, 1'b1, 32'h0000_0104};
    vt[11] = '{2'd2, 3'd0, 2'd0, 5'd0, 32'h55,
               32'h0, 32'h104, 1'b0, 32'h0};
    vt[12] = '{2'd0, 3'd0, 2'd0, 5'd12, 32'h1234_5678,
               32'h0, 32'h200, 1'b1, 32'h1234_5678};
    vt[13] = '{2'd3, 3'd1, 2'd2, 5'd13, 32'hCAFE_F00D,
               32'hFFFF_FFFF, 32'h300, 1'b1, 32'hCAFE_F00D};

    idle_inputs();
    reset = 1'b0;
    m_wait = 0; m_en = 0; m_addr = 0; m_data = 0;
    m_ext_acc = 0;
    #1;
    chk("rst_en", 32'(rg_wrt_en), 32'd0);
    chk("rst_addr", 32'(rg_wrt_addr), 32'd0);
    chk("rst_data", rg_wrt_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Vector table: single main beats
    for (int i = 0; i < 14; i++) begin
      in_valid = 1; in_reg_write = 1;
      in_wb_sel = vt[i].sel; in_funct3 = vt[i].f3;
      in_addr_lo = vt[i].off; in_rd = vt[i].rd;
      in_alu_result = vt[i].alu;
      in_mem_rdata = vt[i].rdata;
      in_pc_plus4 = vt[i].pc4;
      step();
      chk($sformatf("vec%0d_en", i),
          32'(rg_wrt_en), 32'(vt[i].exp_en));
      if (vt[i].exp_en) begin
        chk($sformatf("vec%0d_data", i),
            rg_wrt_data, vt[i].exp_data);
        chk($sformatf("vec%0d_addr", i),
            32'(rg_wrt_addr), 32'(vt[i].rd));
      end
    end
    idle_inputs();
    step();

    // Starvation under continuous main traffic
    in_valid = 1; in_reg_write = 1; in_rd = 5'd3;
    ext_valid = 1; ext_rd = 5'd9; ext_data = 32'hDEAD_0009;
    for (int i = 0; i < 5; i++) begin
      in_alu_result = 32'(i + 100);
      #1;
      chk($sformatf("starve%0d_er", i),
          32'(ext_ready), 32'(i == 4));
      chk($sformatf("starve%0d_ir", i),
          32'(in_ready), 32'(i != 4));
      step();
    end
    chk("starve_wr_addr", 32'(rg_wrt_addr), 32'd9);
    chk("starve_wr_data", rg_wrt_data, 32'hDEAD_0009);
    ext_valid = 0;
    #1;
    chk("starve_after_ir", 32'(in_ready), 32'd1);
    step();

    // Flush together with ext
    in_valid = 1; in_flush = 1; in_rd = 5'd7;
    in_alu_result = 32'h7777_7777;
    ext_valid = 1; ext_rd = 5'd12; ext_data = 32'hE0E0_0012;
    step();
    chk("flush_en", 32'(rg_wrt_en), 32'd1);
    chk("flush_addr", 32'(rg_wrt_addr), 32'd12);
    chk("flush_data", rg_wrt_data, 32'hE0E0_0012);
    in_flush = 0; ext_data = 32'hE0E0_0013;
    #1;
    chk("flush_wait_clear", 32'(ext_ready), 32'd0);
    step();
    idle_inputs();

    // Idle: outputs hold
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_en", 32'(rg_wrt_en), 32'd0);
    end

    // Reset mid-stream
    in_valid = 1; in_reg_write = 1; in_rd = 5'd5;
    in_alu_result = 32'hABCD_0005;
    step();
    chk("pre_rst_en", 32'(rg_wrt_en), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_en", 32'(rg_wrt_en), 32'd0);
    chk("mid_rst_addr", 32'(rg_wrt_addr), 32'd0);
    chk("mid_rst_data", rg_wrt_data, 32'd0);
    m_wait = 0; m_en = 0; m_addr = 0; m_data = 0;
    @(posedge clk);
    #1;
    chk("hold_rst_en", 32'(rg_wrt_en), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    in_rd = 5'd6; in_alu_result = 32'h6666_0006;
    step();
    chk("post_rst_addr", 32'(rg_wrt_addr), 32'd6);
    chk("post_rst_data", rg_wrt_data, 32'h6666_0006);

    // Random traffic against the model
    idle_inputs();
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom % 4) != 0;
      in_flush = ($urandom % 8) == 0;
      in_reg_write = ($urandom % 5) != 0;
      in_rd = 5'($urandom);
      in_wb_sel = 2'($urandom);
      in_funct3 = 3'($urandom);
      in_addr_lo = 2'($urandom);
      in_alu_result = $urandom;
      in_mem_rdata = $urandom;
      in_pc_plus4 = $urandom;
      if (!ext_valid || m_ext_acc) begin
        ext_valid = ($urandom % 3) == 0;
        ext_rd = 5'($urandom);
        ext_data = $urandom;
      end else if (($urandom % 8) == 0) begin
        ext_valid = 0;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
